// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader_pkg : shared states, image-format constants and state helpers
// Revision 1.0
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_FLUSH   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM    = 3'd5,
`endif
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  function automatic logic accepts_bytes(input state_t s);
    case (s)
      S_HDR0, S_HDR1, S_PAYLOAD: accepts_bytes = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                    accepts_bytes = 1'b1;
`endif
      default:                   accepts_bytes = 1'b0;
    endcase
  endfunction

  function automatic logic is_busy(input state_t s);
    case (s)
      S_HDR0, S_HDR1, S_PAYLOAD, S_FLUSH: is_busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                             is_busy = 1'b1;
`endif
      default:                            is_busy = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader_if : byte-stream input and instruction-memory write port
// Revision 1.0
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: byte source plus memory sink; slave: the loader
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// byte_packer : assembles little-endian 32-bit words from a byte strobe
// Revision 1.0
// ---------------------------------------------------------------------------
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_lane
);

  logic [LANE_W-1:0] lane;
  logic [23:0]       assembly;

  assign last_lane = (lane == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      assembly   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane     <= '0;
        assembly <= '0;
      end else if (strobe) begin
        lane <= lane + LANE_W'(1);
        case (lane)
          2'd0:    assembly[7:0]   <= data;
          2'd1:    assembly[15:8]  <= data;
          2'd2:    assembly[23:16] <= data;
          default: begin
            // word is held stable here so the write data does not ripple
            // while the next word's lanes are filling
            word       <= {data, assembly};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader : boot loader streaming an image into instruction memory.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);

  state_t      state, state_nxt;
  logic [15:0] n_words;
  logic        rx_ready_q;
  logic        rx_ready_nxt, busy_nxt, done_nxt, error_nxt, core_rst_nxt;

  logic        hs;
  logic        load_go;
  logic        pk_strobe;
  logic        final_hs;
  logic [31:0] pk_word;
  logic        pk_valid;
  logic        pk_last_lane;
  logic [15:0] hdr_n;
  logic        last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;
`endif

  assign hs        = bus.rx_valid & rx_ready_q;
  assign load_go   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign pk_strobe = hs && (state == S_PAYLOAD);
  assign hdr_n     = {bus.rx_data, n_words[7:0]};
  assign last_word = (words_loaded == n_words - 16'd1);
  // the final payload byte drops rx_ready at once so trailing bytes are not
  // consumed as payload during the write cycle
  assign final_hs  = pk_strobe && pk_last_lane && last_word;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_go),
    .strobe     (pk_strobe),
    .data       (bus.rx_data),
    .word       (pk_word),
    .word_valid (pk_valid),
    .last_lane  (pk_last_lane)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_HDR0;
      S_HDR0:                  if (hs) state_nxt = S_HDR1;
      S_HDR1: begin
        if (hs) begin
          if (hdr_n > 16'(IMEM_DEPTH)) state_nxt = S_ERROR;
          else if (hdr_n == 16'd0)     state_nxt = S_FLUSH;
          else                         state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD:               if (pk_valid && last_word) state_nxt = S_FLUSH;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_FLUSH:                 state_nxt = S_CSUM;
      S_CSUM: begin
        if (hs) state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERROR;
      end
`else
      S_FLUSH:                 state_nxt = S_DONE;
`endif
      default:                 state_nxt = S_IDLE;
    endcase

    rx_ready_nxt = accepts_bytes(state_nxt) && !final_hs;
    busy_nxt     = is_busy(state_nxt);
    done_nxt     = (state_nxt == S_DONE);
    error_nxt    = (state_nxt == S_ERROR);
    core_rst_nxt = (state_nxt != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      rx_ready_q <= rx_ready_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      core_rst   <= core_rst_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_words      <= '0;
      words_loaded <= '0;
    end else begin
      if (state == S_HDR0 && hs) n_words[7:0]  <= bus.rx_data;
      if (state == S_HDR1 && hs) n_words[15:8] <= bus.rx_data;
      if (load_go)       words_loaded <= '0;
      else if (pk_valid) words_loaded <= words_loaded + 16'd1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            csum <= '0;
    else if (load_go)   csum <= '0;
    else if (pk_strobe) csum <= csum + bus.rx_data;
  end
`endif

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = pk_valid;
  assign bus.imem_wdata = pk_word;
  assign bus.imem_addr  = words_loaded[ADDR_W-1:0];

endmodule
`default_nettype wire
